// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store alignment unit.
//   size_e       access size encoding (byte / half / word / reserved)
//   lsu_state_e  beat sequencer states
//   LANE_MASK    unshifted byte-lane mask per access size
//   align_mask   address bits that must be zero for a naturally aligned access
//   extend_load  truncate right-justified load data to size, then sign/zero extend
package lsu_pkg;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_RSV} size_e;

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} lsu_state_e;

   // Indexed by size_e; reserved size touches no lanes.
   localparam logic [3:0][3:0] LANE_MASK = {4'h0, 4'hF, 4'h3, 4'h1};

   function automatic logic [1:0] align_mask(input size_e size);
      case (size)
         SZ_H:    return 2'b01;
         SZ_W:    return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [31:0] extend_load(input logic [31:0] data,
                                               input size_e       size,
                                               input logic        is_unsigned);
      case (size)
         SZ_B:    return is_unsigned ? {24'h0, data[7:0]}  : {{24{data[7]}}, data[7:0]};
         SZ_H:    return is_unsigned ? {16'h0, data[15:0]} : {{16{data[15]}}, data[15:0]};
         default: return data;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align_if.sv
// lsu_align_if: request/response handshake plus memory data port of the LSU.
//   req_*   execute-stage request (valid/ready), sampled only on acceptance
//   resp_*  one-cycle completion pulse with extended load data and error flag
//   data_*  word-aligned memory port; data_rdata is combinational from memory
// Modports: slave = the LSU itself, master = execute stage + memory side.
interface lsu_align_if #(parameter int ADDR_W = 32);

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] data_addr;
   logic [31:0]       data_wdata;
   logic [3:0]        data_we;
   logic              data_re;
   logic [31:0]       data_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, data_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             data_addr, data_wdata, data_we, data_re
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, data_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             data_addr, data_wdata, data_we, data_re
   );

endinterface

// File: rtl/lsu_lane_shift.sv
// lsu_lane_shift: combinational lane datapath shared by the beat and response paths.
//   off/size/is_unsigned  captured request attributes
//   wdata                 right-justified store data
//   lo/hi                 load words captured in BEAT0/BEAT1
//   wdata_sh              store data shifted into a two-word (64-bit) lane window
//   mask                  8-bit byte-lane mask over the same two-word window
//   rdata_ext             load data shifted down, truncated and extended
module lsu_lane_shift
   import lsu_pkg::*;
(
   input  logic [1:0]  off,
   input  size_e       size,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   input  logic [31:0] lo,
   input  logic [31:0] hi,
   output logic [63:0] wdata_sh,
   output logic [7:0]  mask,
   output logic [31:0] rdata_ext
);

   logic [31:0] rd_shifted;

   assign wdata_sh   = {32'h0, wdata} << {off, 3'b000};
   assign mask       = {4'h0, LANE_MASK[size]} << off;
   // Bytes beyond the access size come from the stale other word; extend_load drops them.
   assign rd_shifted = 32'({hi, lo} >> {off, 3'b000});
   assign rdata_ext  = extend_load(rd_shifted, size, is_unsigned);

endmodule

// File: rtl/lsu_align.sv
// lsu_align: load/store unit in front of the unified memory data port.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   lsu_align_if.slave: req_* handshake in, resp_* pulse out, data_* memory port
// Accesses crossing a word boundary are split into BEAT0 (low word) and BEAT1
// (next word, address wraps modulo 2^ADDR_W).
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses
// (resp_err, no memory traffic) instead of splitting them.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
)
(
   input  logic        clk,
   input  logic        rst,
   lsu_align_if.slave  bus
);

   lsu_state_e        state, state_nxt;
   logic              we_q, uns_q, err_q, err_nxt;
   size_e             size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q, lo_q, hi_q;
   logic              accept, misalign;
   logic [ADDR_W-1:0] word_addr;
   logic [63:0]       wsh;
   logic [7:0]        mask;
   logic [31:0]       rdata_ext;

   assign accept    = (state == IDLE) && bus.req_valid;
   assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = (bus.req_addr[1:0] & align_mask(size_e'(bus.req_size))) != 2'b00;
`else
   assign misalign = 1'b0;
`endif

   assign err_nxt = (size_e'(bus.req_size) == SZ_RSV) || misalign;

   lsu_lane_shift u_shift (
      .off         (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (uns_q),
      .wdata       (wdata_q),
      .lo          (lo_q),
      .hi          (hi_q),
      .wdata_sh    (wsh),
      .mask        (mask),
      .rdata_ext   (rdata_ext)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) err_q <= err_nxt;
      end
   end

   // Request and load-data holding registers need no reset: every use is gated by state.
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= bus.req_we;
         size_q  <= size_e'(bus.req_size);
         uns_q   <= bus.req_unsigned;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
      end
      if (state == BEAT0 && !we_q) lo_q <= bus.data_rdata;
      if (state == BEAT1 && !we_q) hi_q <= bus.data_rdata;
   end

   always_comb begin
      state_nxt      = state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_rdata = 32'h0;
      bus.resp_err   = 1'b0;
      bus.data_addr  = '0;
      bus.data_wdata = 32'h0;
      bus.data_we    = 4'h0;
      bus.data_re    = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_nxt = err_nxt ? RESP : BEAT0;
         end
         BEAT0: begin
            bus.data_addr  = word_addr;
            bus.data_we    = we_q ? mask[3:0] : 4'h0;
            bus.data_re    = !we_q;
            bus.data_wdata = wsh[31:0];
            state_nxt      = (mask[7:4] != 4'h0) ? BEAT1 : RESP;
         end
         BEAT1: begin
            bus.data_addr  = word_addr + ADDR_W'(4);
            bus.data_we    = we_q ? mask[7:4] : 4'h0;
            bus.data_re    = !we_q;
            bus.data_wdata = wsh[63:32];
            state_nxt      = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_err   = err_q;
            bus.resp_rdata = (we_q || err_q) ? 32'h0 : rdata_ext;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lsu_align.sv
module tb_lsu_align;

   logic clk;
   logic rst;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   lsu_align_if #(.ADDR_W(32)) bus ();

   lsu_align #(.ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 1K-word memory model; high address bits alias, so 0xFFFFFFFC maps to word 0x3FF.
   logic [31:0] mem [0:1023];
   assign bus.data_rdata = mem[bus.data_addr[11:2]];
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (bus.data_we[b]) mem[bus.data_addr[11:2]][8*b +: 8] <= bus.data_wdata[8*b +: 8];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Present a request for one cycle, then scramble the inputs to show they are ignored.
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      check("req_ready_idle", {31'h0, bus.req_ready}, 32'h1);
      tick();
      bus.req_valid    = 1'b0;
      bus.req_we       = ~we;
      bus.req_size     = 2'd3;
      bus.req_unsigned = ~uns;
      bus.req_addr     = ~addr;
      bus.req_wdata    = ~wdata;
   endtask

   // Aligned access: BEAT0 now, RESP next, then back to IDLE.
   task automatic finish_aligned(input string tag, input logic [31:0] exp_rdata);
      tick();
      check({tag, "_valid"}, {31'h0, bus.resp_valid}, 32'h1);
      check({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
      check({tag, "_err"},   {31'h0, bus.resp_err}, 32'h0);
      tick();
      check({tag, "_done"},  {31'h0, bus.resp_valid}, 32'h0);
   endtask

   initial begin
      rst              = 1'b1;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0;
      bus.req_wdata    = 32'h0;
      #2;
      check("rst_ready",  {31'h0, bus.req_ready}, 32'h1);
      check("rst_rvalid", {31'h0, bus.resp_valid}, 32'h0);
      check("rst_we",     {28'h0, bus.data_we}, 32'h0);
      check("rst_re",     {31'h0, bus.data_re}, 32'h0);
      check("rst_addr",   bus.data_addr, 32'h0);
      check("rst_rdata",  bus.resp_rdata, 32'h0);
      tick();
      tick();
      rst = 1'b0;

      // SW 0xDEADBEEF @0x100
      issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
      check("sw_ready",  {31'h0, bus.req_ready}, 32'h0);
      check("sw_addr",   bus.data_addr, 32'h100);
      check("sw_we",     {28'h0, bus.data_we}, 32'hF);
      check("sw_wdata",  bus.data_wdata, 32'hDEADBEEF);
      check("sw_re",     {31'h0, bus.data_re}, 32'h0);
      finish_aligned("sw_resp", 32'h0);

      // LW @0x100
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
      check("lw_re", {31'h0, bus.data_re}, 32'h1);
      check("lw_we", {28'h0, bus.data_we}, 32'h0);
      finish_aligned("lw_resp", 32'hDEADBEEF);

      // SW 0x11223344 @0x200, LB @0x203
      issue(1'b1, 2'd2, 1'b0, 32'h200, 32'h11223344);
      finish_aligned("sw2", 32'h0);
      issue(1'b0, 2'd0, 1'b0, 32'h203, 32'h0);
      check("lb203_addr", bus.data_addr, 32'h200);
      finish_aligned("lb203", 32'h00000011);

      // SB 0x80 @0x201, then LB/LBU @0x201
      issue(1'b1, 2'd0, 1'b0, 32'h201, 32'h00000080);
      check("sb_we",    {28'h0, bus.data_we}, 32'h2);
      check("sb_wdata", bus.data_wdata, 32'h00008000);
      finish_aligned("sb", 32'h0);
      issue(1'b0, 2'd0, 1'b0, 32'h201, 32'h0);
      finish_aligned("lb201", 32'hFFFFFF80);
      issue(1'b0, 2'd0, 1'b1, 32'h201, 32'h0);
      finish_aligned("lbu201", 32'h00000080);
      issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
      finish_aligned("lw200", 32'h11228044);

`ifndef LSU_MISALIGN_TRAP_EN
      // SH 0xA1B2 @0x103 splits across words 0x100 and 0x104
      issue(1'b1, 2'd1, 1'b0, 32'h103, 32'h0000A1B2);
      check("sh_b0_addr",  bus.data_addr, 32'h100);
      check("sh_b0_we",    {28'h0, bus.data_we}, 32'h8);
      check("sh_b0_wdata", bus.data_wdata, 32'hB2000000);
      tick();
      check("sh_b1_addr",  bus.data_addr, 32'h104);
      check("sh_b1_we",    {28'h0, bus.data_we}, 32'h1);
      check("sh_b1_wdata", bus.data_wdata, 32'h000000A1);
      check("sh_b1_rvalid", {31'h0, bus.resp_valid}, 32'h0);
      finish_aligned("sh", 32'h0);
      issue(1'b0, 2'd1, 1'b1, 32'h103, 32'h0);
      tick();
      check("lhu_b1_re", {31'h0, bus.data_re}, 32'h1);
      finish_aligned("lhu103", 32'h0000A1B2);
      issue(1'b0, 2'd1, 1'b0, 32'h103, 32'h0);
      tick();
      finish_aligned("lh103", 32'hFFFFA1B2);
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
      finish_aligned("lw100_after_sh", 32'hB2ADBEEF);

      // LW @0xFFFFFFFE wraps the second beat to address 0
      issue(1'b1, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h55667788);
      finish_aligned("sw_top", 32'h0);
      issue(1'b1, 2'd2, 1'b0, 32'h00000000, 32'h99AABBCC);
      finish_aligned("sw_zero", 32'h0);
      issue(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0);
      check("wrap_b0_addr", bus.data_addr, 32'hFFFFFFFC);
      tick();
      check("wrap_b1_addr", bus.data_addr, 32'h00000000);
      finish_aligned("lw_wrap", 32'hBBCC5566);
`else
      // Misaligned word traps with no memory traffic
      issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
      check("trap_valid", {31'h0, bus.resp_valid}, 32'h1);
      check("trap_err",   {31'h0, bus.resp_err}, 32'h1);
      check("trap_rdata", bus.resp_rdata, 32'h0);
      check("trap_re",    {31'h0, bus.data_re}, 32'h0);
      check("trap_we",    {28'h0, bus.data_we}, 32'h0);
      tick();
      check("trap_done",  {31'h0, bus.resp_valid}, 32'h0);
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
      finish_aligned("trap_lw_aligned", 32'hDEADBEEF);
`endif

      // Reserved size: error at accept+1, no strobes
      issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
      check("rsv_valid", {31'h0, bus.resp_valid}, 32'h1);
      check("rsv_err",   {31'h0, bus.resp_err}, 32'h1);
      check("rsv_rdata", bus.resp_rdata, 32'h0);
      check("rsv_re",    {31'h0, bus.data_re}, 32'h0);
      check("rsv_we",    {28'h0, bus.data_we}, 32'h0);
      tick();
      check("rsv_done",  {31'h0, bus.resp_valid}, 32'h0);
      check("rsv_ready", {31'h0, bus.req_ready}, 32'h1);

      // Reset asserted during BEAT0 of a store
`ifndef LSU_MISALIGN_TRAP_EN
      issue(1'b1, 2'd2, 1'b0, 32'h301, 32'h12345678);
      check("rstb0_we",    {28'h0, bus.data_we}, 32'hE);
      check("rstb0_wdata", bus.data_wdata, 32'h34567800);
`else
      issue(1'b1, 2'd2, 1'b0, 32'h300, 32'h12345678);
      check("rstb0_we",    {28'h0, bus.data_we}, 32'hF);
`endif
      rst = 1'b1;
      #1;
      check("rstb0_we_drop", {28'h0, bus.data_we}, 32'h0);
      check("rstb0_re_drop", {31'h0, bus.data_re}, 32'h0);
      tick();
      rst = 1'b0;
      check("rstb0_ready",  {31'h0, bus.req_ready}, 32'h1);
      check("rstb0_rvalid", {31'h0, bus.resp_valid}, 32'h0);
      tick();
      check("rstb0_rvalid2", {31'h0, bus.resp_valid}, 32'h0);
      issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
      finish_aligned("post_rst_lw", 32'h11228044);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store unit sitting directly upstream of the data port of the unified simple memory.
- Accepts byte, halfword and word requests from the execute stage over a valid/ready handshake.
- Generates word addresses, byte-lane write enables and lane-shifted write data; extracts and sign- or zero-extends load data.
- Splits accesses that cross a 32-bit word boundary into two memory beats under a small FSM.

Parameters:
- ADDR_W, 32, byte address width; memory-side word address is ADDR_W bits with bits [1:0] forced to 0.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_unsigned  in  1  zero-extend load (LBU/LHU)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  reserved size, or misalignment trap
- data_addr  out  ADDR_W  word-aligned memory address
- data_wdata  out  32  lane-positioned store data
- data_we  out  4  byte write enables; memory writes on posedge clk
- data_re  out  1  read enable
- data_rdata  in  32  combinational read data from memory

Behaviour:
- Reset values: req_ready=1; all other outputs 0; FSM in IDLE.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture the request and compute off=addr[1:0] and lane mask m = {1,3,F}[size] << off (8 bits).
  - size==3: go to RESP with err=1; no memory access.
  - Otherwise go to BEAT0.
- BEAT0:
  - data_addr = {addr[hi:2],2'b00}; data_we = m[3:0] if store; data_re = !we.
  - data_wdata = low word of (zext64(wdata) << 8*off).
  - Load: capture data_rdata into lo.
  - Next state: BEAT1 if m[7:4]!=0, else RESP.
- BEAT1:
  - data_addr = previous word address + 4, modulo 2^ADDR_W (0xFFFFFFFC wraps to 0).
  - data_we = m[7:4]; data_wdata = high word of the shifted data.
  - Load: capture data_rdata into hi. Next state RESP.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - resp_rdata = ({hi,lo} >> 8*off), truncated to size, then sign- or zero-extended.
  - Stores return resp_rdata=0. Next state IDLE.
- req_ready is 0 in every state except IDLE. Back-to-back requests therefore complete every 3 cycles (aligned) or 4 cycles (crossing). No request is accepted in the RESP cycle.
- Latency from acceptance edge to resp_valid: 2 cycles aligned, 3 cycles crossing, 1 cycle for errors.
- Byte accesses never cross. Crossing cases: half at off=3; word at off=1, 2, 3.
- Memory strobes are decoded combinationally from the state register. An async rst deasserts data_we/data_re immediately.
  - Reset between BEAT0 and BEAT1 of a store leaves a partial write. This is accepted; the pipeline flushes on reset.
- req_* inputs are sampled only on acceptance; later changes are ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: any access with (addr & size-mask)!=0 (half odd, word off!=0) goes IDLE→RESP with resp_err=1 and no memory traffic; BEAT1 is unreachable.
- Undefined: misaligned accesses are performed, split as above; resp_err only for size==3.

Decomposition:
- lsu_pkg:
  - size_e enum (SZ_B, SZ_H, SZ_W, SZ_RSV)
  - lsu_state_e enum
  - LANE_MASK constant table
  - function extend_load(data, size, unsigned)
- One sub-module: lsu_lane_shift, purely combinational. Provides the 64-bit store shift, 8-bit lane mask generation and load right-shift/extend. It is shared by the beat datapath and the response path.

Test Plan:
- Aligned word store 0xDEADBEEF @0x100, then LW @0x100 → data_we=F on one beat; resp_rdata=0xDEADBEEF at accept+2.
- Word 0x11223344 @0x200; LB @0x203 → 0x00000011; store 0x80 @0x201 with SB, then LB @0x201 → 0xFFFFFF80 and LBU @0x201 → 0x00000080; SB beat drives data_we=4'b0010, data_wdata=0x00008000.
- SH 0xA1B2 @0x103 (undef macro) → beat0 addr 0x100 we=1000 wdata[31:24]=B2; beat1 addr 0x104 we=0001 wdata[7:0]=A1. LHU @0x103 → 0x0000A1B2 at accept+3.
- LW @0xFFFFFFFE → beat1 data_addr=0x00000000; size=3 request → resp_err=1 at accept+1, data_we/data_re never asserted.
- With LSU_MISALIGN_TRAP_EN: LW @0x102 → resp_err=1, resp_rdata=0, no memory strobes; aligned LW unaffected.
- Assert rst during BEAT0 of a crossing store → data_we drops the same cycle; after release req_ready=1, resp_valid=0, and the next request completes normally.
